// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Optional feature macro: BIN2BCD_MSD_EN (adds msd/msd_pos outputs on bin2bcd_seq).
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam int unsigned ADD3_THRESHOLD = 5;

    // True when DIGITS decimal digits can hold the largest W-bit value.
    function automatic bit digits_ok(input int unsigned w, input int unsigned digits);
        longint unsigned max_val;
        longint unsigned pow10;
        max_val = (64'd1 << w) - 64'd1;
        pow10   = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        return pow10 > max_val;
    endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Single BCD digit corrector for shift-and-add-3: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bin2bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Conditional +3 correction.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock.
// start/done handshake; bcd holds the last result until the next done.
// Optional feature macro: BIN2BCD_MSD_EN (most significant non-zero digit and its index).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*DIGITS-1:0]  bcd
`ifdef BIN2BCD_MSD_EN
    ,
    output logic [3:0]                 msd,
    output logic [$clog2(DIGITS):0]    msd_pos
`endif
);

    localparam int unsigned CNT_W = $clog2(W + 1);
    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned POS_W = $clog2(DIGITS) + 1;

    if (!digits_ok(W, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for W-bit input");
    end

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       bin_sh_q;
    logic [W-1:0]       bin_sh_d;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_d;
    logic [BCD_W-1:0]   corrected;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bin2bcd_add3 u_add3 (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One shift step: corrected digits and remaining binary bits move left together.
    always_comb begin
        {scratch_d, bin_sh_d} = {corrected, bin_sh_q} << 1;
    end

`ifdef BIN2BCD_MSD_EN
    logic [3:0]       msd_q;
    logic [3:0]       msd_d;
    logic [POS_W-1:0] msd_pos_q;
    logic [POS_W-1:0] msd_pos_d;

    // Priority scan of the finishing result: highest non-zero digit wins.
    always_comb begin
        msd_d     = '0;
        msd_pos_d = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) begin
                msd_d     = scratch_d[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                msd_pos_d = POS_W'(i);
            end
        end
    end

    assign msd     = msd_q;
    assign msd_pos = msd_pos_q;
`endif

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bin_sh_q  <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BIN2BCD_MSD_EN
            msd_q     <= '0;
            msd_pos_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= S_SHIFT;
                        bin_sh_q  <= bin;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(W);
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    scratch_q <= scratch_d;
                    bin_sh_q  <= bin_sh_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        bcd_q   <= scratch_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef BIN2BCD_MSD_EN
                        msd_q     <= msd_d;
                        msd_pos_q <= msd_pos_d;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (W=8/DIGITS=3 and W=5/DIGITS=2 instances).
// msd/msd_pos are checked when BIN2BCD_MSD_EN is defined.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    logic        start5;
    logic [4:0]  bin5;
    logic        busy5;
    logic        done5;
    logic [7:0]  bcd5;

`ifdef BIN2BCD_MSD_EN
    logic [3:0]  msd;
    logic [2:0]  msd_pos;
    logic [3:0]  msd5;
    logic [1:0]  msd_pos5;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.W(8), .DIGITS(3)) u_dut (
`ifdef BIN2BCD_MSD_EN
        .msd     (msd),
        .msd_pos (msd_pos),
`endif
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    bin2bcd_seq #(.W(5), .DIGITS(2)) u_dut5 (
`ifdef BIN2BCD_MSD_EN
        .msd     (msd5),
        .msd_pos (msd_pos5),
`endif
        .clk     (clk),
        .rst     (rst),
        .start   (start5),
        .bin     (bin5),
        .busy    (busy5),
        .done    (done5),
        .bcd     (bcd5)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits packed four bits each.
    function automatic int ref_bcd(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: value and index of the highest non-zero decimal digit.
    function automatic void ref_msd(input int v, output int d, output int pos);
        d   = 0;
        pos = 0;
        for (int i = 0; v > 0; i++) begin
            if (v % 10 != 0) begin
                d   = v % 10;
                pos = i;
            end
            v = v / 10;
        end
    endfunction

    // Launch one conversion and wait (bounded) for done; lat = edges from acceptance.
    task automatic convert(input int v, output int lat);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'(v);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int v);
`ifdef BIN2BCD_MSD_EN
        int ed, ep;
`endif
        check({tag, "_bcd"}, int'(bcd), ref_bcd(v));
`ifdef BIN2BCD_MSD_EN
        ref_msd(v, ed, ep);
        check({tag, "_msd"}, int'(msd), ed);
        check({tag, "_msd_pos"}, int'(msd_pos), ep);
`endif
    endtask

    initial begin
        int dir[3] = '{0, 255, 37};
        int lat, v, ndone, bcd_at_done, cyc, last, k, gaps;
        bit set_next;

        rst    = 1'b1;
        start  = 1'b0;
        bin    = '0;
        start5 = 1'b0;
        bin5   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bcd", int'(bcd), 0);
`ifdef BIN2BCD_MSD_EN
        check("rst_msd", int'(msd), 0);
        check("rst_msd_pos", int'(msd_pos), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed values: zero, full scale, mixed digits.
        foreach (dir[i]) begin
            convert(dir[i], lat);
            check("dir_latency", lat, 8);
            check_result("dir", dir[i]);
            @(negedge clk);
            check("dir_done_pulse", int'(done), 0);
            check("dir_bcd_hold", int'(bcd), ref_bcd(dir[i]));
        end

        // Randomized conversions against the decimal model.
        repeat (20) begin
            v = int'($urandom_range(0, 255));
            convert(v, lat);
            check("rnd_latency", lat, 8);
            check_result("rnd", v);
        end

        // start during SHIFT is ignored.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        bcd_at_done = -1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 3) begin
                start = 1'b1;
                bin   = 8'd99;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                bcd_at_done = int'(bcd);
            end
        end
        check("ign_done_count", ndone, 1);
        check("ign_bcd", bcd_at_done, 'h200);
        check("ign_bcd_final", int'(bcd), 'h200);

        // start held high: back-to-back conversions, no idle gap.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd1;
        @(negedge clk);
        bin      = 8'd2;
        k        = 0;
        cyc      = 0;
        last     = 0;
        gaps     = 0;
        set_next = 1'b0;
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (set_next) begin
                bin      = 8'd3;
                set_next = 1'b0;
            end
            if (!busy && !done) gaps++;
            if (done) begin
                k++;
                check("b2b_bcd", int'(bcd), ref_bcd(k));
                if (k > 1) check("b2b_period", cyc - last, 9);
                last = cyc;
                if (k == 1) set_next = 1'b1;
            end
        end
        start = 1'b0;
        check("b2b_count", k, 3);
        check("b2b_gaps", gaps, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-conversion.
        start = 1'b1;
        bin   = 8'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_bcd", int'(bcd), 0);
        @(negedge clk);
        rst = 1'b0;
        convert(128, lat);
        check("post_rst_latency", lat, 8);
        check_result("post_rst", 128);

        // W=5, DIGITS=2: exhaustive sweep.
        for (int s = 0; s < 32; s++) begin
`ifdef BIN2BCD_MSD_EN
            int ed, ep;
`endif
            @(negedge clk);
            start5 = 1'b1;
            bin5   = 5'(s);
            @(negedge clk);
            start5 = 1'b0;
            lat    = 0;
            while (!done5 && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            check("w5_latency", lat, 5);
            check("w5_bcd", int'(bcd5), ref_bcd(s));
`ifdef BIN2BCD_MSD_EN
            ref_msd(s, ed, ep);
            check("w5_msd", int'(msd5), ed);
            check("w5_msd_pos", int'(msd_pos5), ep);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
